lifo_cmd_issuer: RTL and testbench
==================================

Name: lifo_cmd_issuer

Overview:
- Upstream command stage for the LIFO stack. It accepts independent push and pop requests over req/ack handshakes and arbitrates between them.
- It keeps an authoritative occupancy count and blocks push when full and pop when empty. The LIFO's own flags are not used.
- It emits one registered opcode+data vector per operation and captures the popped word returned by the LIFO.

Parameters:
- DATA_WIDTH, 4, width of a stack word.
- NUM_ENTRIES, 8, stack depth; must match the downstream LIFO.
- OPCODE_WIDTH, 2, opcode field width.
- CNT_WIDTH, 4, occupancy counter width; must hold 0..NUM_ENTRIES.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- push_req  in  1  push request; held until push_ack.
- push_data  in  DATA_WIDTH  word to push; stable while push_req=1.
- push_ack  out  1  one-cycle pulse, push accepted.
- pop_req  in  1  pop request; held until pop_ack.
- pop_ack  out  1  one-cycle pulse, pop accepted.
- pop_data  out  DATA_WIDTH  popped word; valid when pop_valid=1.
- pop_valid  out  1  one-cycle pulse, pop_data valid.
- lifo_data_in  in  DATA_WIDTH  LIFO data_out, fed back for pop capture.
- vector_out  out  OPCODE_WIDTH+DATA_WIDTH  {opcode, data} to the LIFO input vector.
- count  out  CNT_WIDTH  current occupancy.
- full  out  1  count==NUM_ENTRIES.
- empty  out  1  count==0.

Behaviour:
- Opcodes: NOP=2'b00, POP=2'b01, PUSH=2'b10. 2'b11 is never driven.
- Reset (asynchronous, reset=0):
  - state=IDLE, vector_out=0 (NOP, data 0).
  - push_ack=0, pop_ack=0, pop_valid=0, pop_data=0.
  - count=0, last_served=POP.
  - empty=1, full=0.
  - Any in-flight pop is dropped and no pop_valid is produced.
  - This reset must be asserted together with the LIFO's reset.
- All outputs are registered except full and empty, which decode count.
- FSM has four states: IDLE, PUSH, POP, POP_CAP.
- IDLE, on each rising edge, evaluates push_ok = push_req & ~full and pop_ok = pop_req & ~empty:
  - Only push_ok: vector_out<={PUSH,push_data}, push_ack<=1, count<=count+1, last_served<=PUSH, go to PUSH.
  - Only pop_ok: vector_out<={POP,0}, pop_ack<=1, count<=count-1, last_served<=POP, go to POP.
  - Both: serve the opposite of last_served (round-robin). After reset, push wins first.
  - Neither: stay in IDLE with vector_out=NOP. A blocked request waits and receives no ack.
- PUSH: at the next edge, vector_out<=NOP, push_ack<=0, go to IDLE. The PUSH word is on vector_out for exactly one cycle, and the LIFO samples it at that edge.
- POP: at the next edge, vector_out<=NOP, pop_ack<=0, go to POP_CAP. The LIFO executes the pop at this edge.
- POP_CAP: at the next edge, pop_data<=lifo_data_in, pop_valid<=1, go to IDLE. pop_valid clears at the following edge.
- Latency:
  - Push costs 2 cycles, accept edge to IDLE.
  - pop_valid rises 2 edges after the pop accept edge.
  - Pop occupies 3 cycles.
  - Peak throughput is one push per 2 cycles or one pop per 3 cycles.
- Requester rules: the requester deasserts req at or after the edge on which it sees ack. IDLE re-evaluates only on the edge after returning, so no double accept occurs.
- Count boundaries: count never exceeds NUM_ENTRIES and never goes below 0. At full, a push is held off while a pop may proceed; at empty, the reverse.
- Simultaneous push and pop in one cycle are never issued. Operations are strictly serialized.
- Data width: push_data maps to vector_out[DATA_WIDTH-1:0] unmodified, and the opcode occupies the MSBs.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release, 5 idle cycles -> vector_out=6'b00_0000 throughout, count=0, empty=1, full=0, no acks.
- Push 4'h3, 4'h9, then pop twice -> vector_out shows 10_0011, then 10_1001 for one cycle each. pop_data=4'h9 then 4'h3, each pop_valid 2 edges after pop_ack. count ends at 0.
- Fill: 8 pushes of 4'h1..4'h8, then a 9th push_req held 10 cycles -> full=1, count=8, no push_ack. A subsequent pop yields 4'h8 and then the held push is acked.
- Empty guard: pop_req from reset held 6 cycles -> no pop_ack, vector_out stays NOP. After one push of 4'hA, pop_ack follows and pop_data=4'hA.
- Contention: with count=2, push_req and pop_req both held continuously -> acks alternate, push first after reset, and count oscillates within 1..3.
- Mid-op reset: assert reset in POP state -> pop_ack, pop_valid and vector_out clear immediately (asynchronous), no pop_valid after release, count=0.

Source files
------------

// File: rtl/lifo_cmd_issuer.sv
// Command issuer in front of the LIFO stack: arbitrates push/pop requests, tracks occupancy,
// drives one {opcode,data} vector per operation and captures the word returned by a pop.
module lifo_cmd_issuer #(
    parameter int DATA_WIDTH   = 4,
    parameter int NUM_ENTRIES  = 8,
    parameter int OPCODE_WIDTH = 2,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push_req,
    input  logic [DATA_WIDTH-1:0]            push_data,
    output logic                             push_ack,
    input  logic                             pop_req,
    output logic                             pop_ack,
    output logic [DATA_WIDTH-1:0]            pop_data,
    output logic                             pop_valid,
    input  logic [DATA_WIDTH-1:0]            lifo_data_in,
    output logic [OPCODE_WIDTH+DATA_WIDTH-1:0] vector_out,
    output logic [CNT_WIDTH-1:0]             count,
    output logic                             full,
    output logic                             empty
);

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_POP  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUSH = OPCODE_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0]    CNT_MAX = CNT_WIDTH'(NUM_ENTRIES);

    typedef enum logic [1:0] {IDLE, PUSH, POP, POP_CAP} state_t;

    state_t state;
    state_t state_next;

    logic                              last_push;
    logic                              last_push_next;
    logic                              push_ok;
    logic                              pop_ok;
    logic                              grant_push;
    logic                              grant_pop;
    logic [OPCODE_WIDTH+DATA_WIDTH-1:0] vector_next;
    logic                              push_ack_next;
    logic                              pop_ack_next;
    logic                              pop_valid_next;
    logic [DATA_WIDTH-1:0]             pop_data_next;
    logic [CNT_WIDTH-1:0]              count_next;

    assign full  = (count == CNT_MAX);
    assign empty = (count == '0);

    // On contention the side not served last wins; last_push resets low so push wins first.
    assign push_ok    = push_req & ~full;
    assign pop_ok     = pop_req & ~empty;
    assign grant_push = (state == IDLE) & push_ok & (~pop_ok | ~last_push);
    assign grant_pop  = (state == IDLE) & pop_ok & ~grant_push;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (grant_push) begin
                    state_next = PUSH;
                end else if (grant_pop) begin
                    state_next = POP;
                end
            end
            PUSH:    state_next = IDLE;
            POP:     state_next = POP_CAP;
            POP_CAP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        vector_next    = {OP_NOP, {DATA_WIDTH{1'b0}}};
        push_ack_next  = 1'b0;
        pop_ack_next   = 1'b0;
        pop_valid_next = 1'b0;
        pop_data_next  = pop_data;
        count_next     = count;
        last_push_next = last_push;
        unique case (state)
            IDLE: begin
                if (grant_push) begin
                    vector_next    = {OP_PUSH, push_data};
                    push_ack_next  = 1'b1;
                    count_next     = count + CNT_WIDTH'(1);
                    last_push_next = 1'b1;
                end else if (grant_pop) begin
                    vector_next    = {OP_POP, {DATA_WIDTH{1'b0}}};
                    pop_ack_next   = 1'b1;
                    count_next     = count - CNT_WIDTH'(1);
                    last_push_next = 1'b0;
                end
            end
            // The LIFO presents the popped word one edge after it executes the pop.
            POP_CAP: begin
                pop_data_next  = lifo_data_in;
                pop_valid_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vector_out <= '0;
            push_ack   <= 1'b0;
            pop_ack    <= 1'b0;
            pop_valid  <= 1'b0;
            pop_data   <= '0;
            count      <= '0;
            last_push  <= 1'b0;
        end else begin
            vector_out <= vector_next;
            push_ack   <= push_ack_next;
            pop_ack    <= pop_ack_next;
            pop_valid  <= pop_valid_next;
            pop_data   <= pop_data_next;
            count      <= count_next;
            last_push  <= last_push_next;
        end
    end

endmodule

// File: tb/tb_lifo_cmd_issuer.sv
// Self-checking bench for lifo_cmd_issuer: a behavioural LIFO closes the loop and a
// scoreboard queue holds the expected popped words.
module tb_lifo_cmd_issuer;

    logic       clk;
    logic       reset;
    logic       push_req;
    logic [3:0] push_data;
    logic       push_ack;
    logic       pop_req;
    logic       pop_ack;
    logic [3:0] pop_data;
    logic       pop_valid;
    logic [3:0] lifo_q;
    logic [5:0] vector_out;
    logic [3:0] count;
    logic       full;
    logic       empty;

    int n_checks;
    int n_errors;
    logic [3:0] ref_stk[$];
    logic [3:0] exp_q[$];
    int mdl_count;
    bit mdl_last_push;

    lifo_cmd_issuer #(
        .DATA_WIDTH(4), .NUM_ENTRIES(8), .OPCODE_WIDTH(2), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .push_req(push_req), .push_data(push_data), .push_ack(push_ack),
        .pop_req(pop_req), .pop_ack(pop_ack), .pop_data(pop_data), .pop_valid(pop_valid),
        .lifo_data_in(lifo_q), .vector_out(vector_out),
        .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural downstream LIFO driven by vector_out, with registered data_out.
    logic [3:0] lifo_mem [0:7];
    logic [3:0] lifo_sp;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            lifo_sp <= 4'd0;
            lifo_q  <= 4'd0;
        end else begin
            case (vector_out[5:4])
                2'b10: if (lifo_sp < 4'd8) begin
                    lifo_mem[lifo_sp[2:0]] <= vector_out[3:0];
                    lifo_sp <= lifo_sp + 4'd1;
                end
                2'b01: if (lifo_sp > 4'd0) begin
                    lifo_q  <= lifo_mem[lifo_sp[2:0] - 3'd1];
                    lifo_sp <= lifo_sp - 4'd1;
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : pop_monitor
        logic [3:0] e;
        if (reset === 1'b1 && pop_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("pop_valid_unexpected", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("pop_data", 32'(pop_data), 32'(e));
            end
        end
    end

    task automatic wait_ack(input bit is_push, input int max_cyc, output bit got);
        got = 1'b0;
        for (int n = 0; n < max_cyc && !got; n++) begin
            @(negedge clk);
            if (is_push ? push_ack : pop_ack) got = 1'b1;
        end
        if (!got) chk(is_push ? "push_ack_timeout" : "pop_ack_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        push_req = 1'b0;
        pop_req = 1'b0;
        #1;
        chk("rst_vector", 32'(vector_out), 32'(0));
        chk("rst_push_ack", 32'(push_ack), 32'(0));
        chk("rst_pop_ack", 32'(pop_ack), 32'(0));
        chk("rst_pop_valid", 32'(pop_valid), 32'(0));
        chk("rst_pop_data", 32'(pop_data), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        exp_q.delete();
        ref_stk.delete();
        mdl_count = 0;
        mdl_last_push = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push_op(input logic [3:0] d);
        bit got;
        @(negedge clk);
        push_req = 1'b1;
        push_data = d;
        wait_ack(1'b1, 40, got);
        push_req = 1'b0;
        if (got) begin
            chk("push_vector", 32'(vector_out), 32'({2'b10, d}));
            ref_stk.push_back(d);
            mdl_count++;
            mdl_last_push = 1'b1;
            chk("push_count", 32'(count), 32'(mdl_count));
            @(negedge clk);
            chk("push_vector_nop", 32'(vector_out), 32'(0));
            chk("push_ack_pulse", 32'(push_ack), 32'(0));
        end
    endtask

    task automatic pop_op();
        bit got;
        @(negedge clk);
        pop_req = 1'b1;
        wait_ack(1'b0, 40, got);
        pop_req = 1'b0;
        if (got) begin
            chk("pop_vector", 32'(vector_out), 32'(6'b01_0000));
            if (ref_stk.size() > 0) exp_q.push_back(ref_stk.pop_back());
            mdl_count--;
            mdl_last_push = 1'b0;
            chk("pop_count", 32'(count), 32'(mdl_count));
            @(negedge clk);
            chk("pop_vector_nop", 32'(vector_out), 32'(0));
            chk("pop_valid_early", 32'(pop_valid), 32'(0));
            @(negedge clk);
            chk("pop_valid_latency", 32'(pop_valid), 32'(1));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit got;
        int acks;
        int vbad;
        int oob;
        bit exp_next_push;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        push_req = 1'b0;
        pop_req = 1'b0;
        push_data = 4'h0;

        // Reset then idle
        @(negedge clk);
        do_reset();
        repeat (5) begin
            @(negedge clk);
            chk("idle_vector", 32'(vector_out), 32'(0));
            chk("idle_acks", 32'({push_ack, pop_ack, pop_valid}), 32'(0));
            chk("idle_count", 32'(count), 32'(0));
            chk("idle_flags", 32'({empty, full}), 32'(2'b10));
        end

        // Push 3, 9 then pop twice
        push_op(4'h3);
        push_op(4'h9);
        pop_op();
        pop_op();
        repeat (2) @(negedge clk);
        chk("basic_count_end", 32'(count), 32'(0));
        chk("basic_empty_end", 32'(empty), 32'(1));

        // Fill and hold off the ninth push
        @(negedge clk);
        do_reset();
        for (int i = 1; i <= 8; i++) push_op(4'(i));
        chk("fill_full", 32'(full), 32'(1));
        chk("fill_count", 32'(count), 32'(8));
        @(negedge clk);
        push_req = 1'b1;
        push_data = 4'hC;
        acks = 0;
        vbad = 0;
        repeat (10) begin
            @(negedge clk);
            if (push_ack) acks++;
            if (vector_out != 6'd0) vbad++;
        end
        chk("full_no_ack", 32'(acks), 32'(0));
        chk("full_vector_nop", 32'(vbad), 32'(0));
        chk("full_still_count", 32'(count), 32'(8));
        pop_req = 1'b1;
        wait_ack(1'b0, 20, got);
        pop_req = 1'b0;
        if (got) begin
            chk("full_pop_vector", 32'(vector_out), 32'(6'b01_0000));
            exp_q.push_back(ref_stk.pop_back());
            mdl_count--;
            mdl_last_push = 1'b0;
        end
        wait_ack(1'b1, 20, got);
        push_req = 1'b0;
        if (got) begin
            chk("full_held_push_vector", 32'(vector_out), 32'(6'b10_1100));
            ref_stk.push_back(4'hC);
            mdl_count++;
            mdl_last_push = 1'b1;
        end
        @(negedge clk);
        chk("full_refill_count", 32'(count), 32'(mdl_count));
        chk("full_refill_flag", 32'(full), 32'(1));
        chk("full_scoreboard_drained", 32'(exp_q.size()), 32'(0));

        // Empty guard
        @(negedge clk);
        do_reset();
        pop_req = 1'b1;
        acks = 0;
        vbad = 0;
        repeat (6) begin
            @(negedge clk);
            if (pop_ack) acks++;
            if (vector_out != 6'd0) vbad++;
        end
        chk("empty_no_ack", 32'(acks), 32'(0));
        chk("empty_vector_nop", 32'(vbad), 32'(0));
        pop_req = 1'b0;
        push_op(4'hA);
        pop_op();
        @(negedge clk);
        chk("empty_guard_end", 32'(empty), 32'(1));

        // Contention with count=2: round-robin, starting opposite the last served
        @(negedge clk);
        do_reset();
        push_op(4'h5);
        push_op(4'h6);
        @(negedge clk);
        push_data = 4'h1;
        push_req = 1'b1;
        pop_req = 1'b1;
        exp_next_push = ~mdl_last_push;
        acks = 0;
        oob = 0;
        repeat (40) begin
            @(negedge clk);
            if (push_ack) begin
                chk("rr_order", 32'(1), 32'(exp_next_push));
                ref_stk.push_back(push_data);
                mdl_count++;
                push_data = push_data + 4'd1;
                exp_next_push = 1'b0;
                acks++;
            end else if (pop_ack) begin
                chk("rr_order", 32'(0), 32'(exp_next_push));
                if (ref_stk.size() > 0) exp_q.push_back(ref_stk.pop_back());
                mdl_count--;
                exp_next_push = 1'b1;
                acks++;
            end
            if (count < 4'd1 || count > 4'd3) oob++;
        end
        push_req = 1'b0;
        pop_req = 1'b0;
        chk("contention_range", 32'(oob), 32'(0));
        chk("contention_progress", 32'(acks >= 6), 32'(1));
        repeat (5) @(negedge clk);
        chk("contention_count", 32'(count), 32'(mdl_count));
        chk("contention_drained", 32'(exp_q.size()), 32'(0));

        // Reset while a pop is in flight
        push_op(4'h7);
        @(negedge clk);
        pop_req = 1'b1;
        wait_ack(1'b0, 20, got);
        chk("midop_in_pop", 32'({got, vector_out}), 32'({1'b1, 6'b01_0000}));
        do_reset();
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (pop_valid) acks++;
        end
        chk("midop_no_pop_valid", 32'(acks), 32'(0));
        chk("midop_count", 32'(count), 32'(0));
        chk("midop_empty", 32'(empty), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
